// File: rtl/mac_stop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_stop_ctrl
// Description : Sequencer for the mac_stop_mem matrix store. On a start pulse
//               it computes C = A x B (A is MxK, B is KxN). A and B are read
//               one element at a time, each dot product is accumulated, and
//               every C element is written back in row-major order. A
//               synchronous abort returns the block to IDLE from any state.
//               Build option: define MAC_STOP_CTRL_SIGNED_EN to treat
//               operands as two's complement. Left undefined, the default
//               build uses unsigned, zero-extended arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_stop_ctrl #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(M)-1:0]                row_addr_a,
    output logic [$clog2(K)-1:0]                col_addr_a,
    output logic [$clog2(K)-1:0]                row_addr_b,
    output logic [$clog2(N)-1:0]                col_addr_b,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
    output logic [$clog2(M)-1:0]                row_addr_c,
    output logic [$clog2(N)-1:0]                col_addr_c,
    output logic                                matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c
);

    localparam int c_AW_M = $clog2(M);
    localparam int c_AW_K = $clog2(K);
    localparam int c_AW_N = $clog2(N);
    localparam int c_DW   = DATA_WIDTH_INIT_MATRIX;
    localparam int c_RW   = DATA_WIDTH_RESULT_MATRIX;
    localparam int c_PAD  = c_RW - 2*c_DW;

    localparam logic [c_AW_M-1:0] c_I_LAST = c_AW_M'(M-1);
    localparam logic [c_AW_K-1:0] c_K_LAST = c_AW_K'(K-1);
    localparam logic [c_AW_N-1:0] c_J_LAST = c_AW_N'(N-1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [c_AW_M-1:0] r_i;
    logic [c_AW_N-1:0] r_j;
    logic [c_AW_K-1:0] r_k;
    logic [c_RW-1:0]   r_acc;

    logic [2:0]        w_nxt_state;
    logic [c_AW_M-1:0] w_nxt_i;
    logic [c_AW_N-1:0] w_nxt_j;
    logic [c_AW_K-1:0] w_nxt_k;

    logic [c_AW_M-1:0] r_row_a;
    logic [c_AW_K-1:0] r_col_a;
    logic [c_AW_K-1:0] r_row_b;
    logic [c_AW_N-1:0] r_col_b;
    logic [c_AW_M-1:0] r_row_c;
    logic [c_AW_N-1:0] r_col_c;
    logic              r_re;
    logic              r_we;
    logic              r_busy;
    logic              r_done;

    // ------------------------------------------------------------------
    // Operand extension and product. Operands are widened to 2*DW so the
    // product is exact, then padded up to the accumulator width.
    // ------------------------------------------------------------------
    logic [2*c_DW-1:0] w_a_ext;
    logic [2*c_DW-1:0] w_b_ext;
    logic [2*c_DW-1:0] w_prod;
    logic [c_RW-1:0]   w_prod_ext;
    logic              w_prod_sign;

`ifdef MAC_STOP_CTRL_SIGNED_EN
    assign w_a_ext     = {{c_DW{data_out_a[c_DW-1]}}, data_out_a};
    assign w_b_ext     = {{c_DW{data_out_b[c_DW-1]}}, data_out_b};
    assign w_prod_sign = w_prod[2*c_DW-1];
`else
    assign w_a_ext     = {{c_DW{1'b0}}, data_out_a};
    assign w_b_ext     = {{c_DW{1'b0}}, data_out_b};
    assign w_prod_sign = 1'b0;
`endif

    assign w_prod = w_a_ext * w_b_ext;

    generate
        if (c_PAD > 0) begin : g_pad
            assign w_prod_ext = {{c_PAD{w_prod_sign}}, w_prod};
        end else begin : g_nopad
            assign w_prod_ext = w_prod[c_RW-1:0];
        end
    endgenerate

    // Next-state and next-counter decode; abort overrides every busy state
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_i     = r_i;
        w_nxt_j     = r_j;
        w_nxt_k     = r_k;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_nxt_state = S_FETCH;
                    w_nxt_i     = '0;
                    w_nxt_j     = '0;
                    w_nxt_k     = '0;
                end
            end
            S_FETCH: begin
                w_nxt_state = S_MAC;
            end
            S_MAC: begin
                if (r_k == c_K_LAST) begin
                    w_nxt_state = S_WRITE;
                end else begin
                    w_nxt_k     = r_k + 1'b1;
                    w_nxt_state = S_FETCH;
                end
            end
            S_WRITE: begin
                w_nxt_k = '0;
                if (r_j != c_J_LAST) begin
                    w_nxt_j     = r_j + 1'b1;
                    w_nxt_state = S_FETCH;
                end else if (r_i != c_I_LAST) begin
                    w_nxt_j     = '0;
                    w_nxt_i     = r_i + 1'b1;
                    w_nxt_state = S_FETCH;
                end else begin
                    w_nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_nxt_state = S_IDLE;
        end
    end

    // State and loop counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_i     <= w_nxt_i;
            r_j     <= w_nxt_j;
            r_k     <= w_nxt_k;
        end
    end

    // Accumulator: cleared on start and after each write, summed in MAC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
        end else if ((r_state == S_IDLE) && (w_nxt_state == S_FETCH)) begin
            r_acc <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= r_acc + w_prod_ext;
        end else if (r_state == S_WRITE) begin
            r_acc <= '0;
        end
    end

    // Registered outputs decoded from the upcoming state; addresses load
    // only when their strobe is about to rise and hold otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row_a <= '0;
            r_col_a <= '0;
            r_row_b <= '0;
            r_col_b <= '0;
            r_row_c <= '0;
            r_col_c <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_re   <= (w_nxt_state == S_FETCH);
            r_we   <= (w_nxt_state == S_WRITE);
            r_busy <= (w_nxt_state != S_IDLE);
            r_done <= (w_nxt_state == S_DONE);
            if (w_nxt_state == S_FETCH) begin
                r_row_a <= w_nxt_i;
                r_col_a <= w_nxt_k;
                r_row_b <= w_nxt_k;
                r_col_b <= w_nxt_j;
            end
            if (w_nxt_state == S_WRITE) begin
                r_row_c <= w_nxt_i;
                r_col_c <= w_nxt_j;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign row_addr_a  = r_row_a;
    assign col_addr_a  = r_col_a;
    assign row_addr_b  = r_row_b;
    assign col_addr_b  = r_col_b;
    assign matrix_a_re = r_re;
    assign matrix_b_re = r_re;
    assign row_addr_c  = r_row_c;
    assign col_addr_c  = r_col_c;
    assign matrix_c_we = r_we;
    assign data_in_c   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mac_stop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_stop_ctrl
// Description : Self-checking bench for mac_stop_ctrl. A behavioural model
//               derives the expected outputs from the cycle count since the
//               accepted start; a memory model serves A/B and captures C.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_stop_ctrl;

    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 2*DW + $clog2(K);
    localparam int PER_ELEM = 2*K + 1;
    localparam int TOTAL    = M*N*PER_ELEM;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           busy, done;
    logic [1:0]     row_addr_a, col_addr_a, row_addr_b, col_addr_b;
    logic [1:0]     row_addr_c, col_addr_c;
    logic           matrix_a_re, matrix_b_re, matrix_c_we;
    logic [DW-1:0]  data_out_a = '0;
    logic [DW-1:0]  data_out_b = '0;
    logic [RW-1:0]  data_in_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_a [M][K];
    logic [DW-1:0] mem_b [K][N];
    logic [RW-1:0] mem_c [M][N];
    bit            wr_flag [M][N];
    int            wr_count = 0;

    mac_stop_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .row_addr_a  (row_addr_a),
        .col_addr_a  (col_addr_a),
        .row_addr_b  (row_addr_b),
        .col_addr_b  (col_addr_b),
        .matrix_a_re (matrix_a_re),
        .matrix_b_re (matrix_b_re),
        .data_out_a  (data_out_a),
        .data_out_b  (data_out_b),
        .row_addr_c  (row_addr_c),
        .col_addr_c  (col_addr_c),
        .matrix_c_we (matrix_c_we),
        .data_in_c   (data_in_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: one-cycle read latency, C written on the strobe
    always @(posedge clk) begin
        if (matrix_a_re) data_out_a <= mem_a[row_addr_a][col_addr_a];
        if (matrix_b_re) data_out_b <= mem_b[row_addr_b][col_addr_b];
        if (matrix_c_we) begin
            mem_c[row_addr_c][col_addr_c]   <= data_in_c;
            wr_flag[row_addr_c][col_addr_c] <= 1'b1;
            wr_count                        <= wr_count + 1;
        end
    end

    // Reference product
    function automatic logic [RW-1:0] ref_c(input int i, input int j);
        logic [RW-1:0] s;
        s = '0;
        for (int k = 0; k < K; k++) begin
`ifdef MAC_STOP_CTRL_SIGNED_EN
            s += RW'($signed(mem_a[i][k])) * RW'($signed(mem_b[k][j]));
`else
            s += RW'(mem_a[i][k]) * RW'(mem_b[k][j]);
`endif
        end
        return s;
    endfunction

    // Behavioural model: t counts cycles since the accepting edge; within
    // each element the first 2K cycles alternate fetch/mac, then one write
    bit   m_active = 0;
    int   m_t = 0;
    logic e_busy, e_done, e_re, e_we;
    logic [1:0] e_ra, e_ca, e_rb, e_cb, e_rc, e_cc;
    logic [RW-1:0] e_data;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 0; m_t = 0;
            e_busy = 0; e_done = 0; e_re = 0; e_we = 0;
            e_ra = 0; e_ca = 0; e_rb = 0; e_cb = 0; e_rc = 0; e_cc = 0;
            e_data = '0;
        end else begin
            if (m_active) begin
                if (abort || m_t == TOTAL + 1) m_active = 0;
                else m_t++;
            end else if (start && !abort) begin
                m_active = 1;
                m_t = 1;
            end
            e_busy = m_active;
            e_done = 0; e_re = 0; e_we = 0;
            if (m_active) begin
                if (m_t == TOTAL + 1) begin
                    e_done = 1;
                end else begin
                    int e, p, ii, jj;
                    e  = (m_t - 1) / PER_ELEM;
                    p  = (m_t - 1) % PER_ELEM;
                    ii = e / N;
                    jj = e % N;
                    if (p == 2*K) begin
                        e_we = 1; e_rc = 2'(ii); e_cc = 2'(jj);
                        e_data = ref_c(ii, jj);
                    end else if (p % 2 == 0) begin
                        e_re = 1;
                        e_ra = 2'(ii); e_ca = 2'(p/2); e_rb = 2'(p/2); e_cb = 2'(jj);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("re_a", matrix_a_re, e_re);
        chk("re_b", matrix_b_re, e_re);
        chk("we", matrix_c_we, e_we);
        chk("addr_a", {row_addr_a, col_addr_a}, {e_ra, e_ca});
        chk("addr_b", {row_addr_b, col_addr_b}, {e_rb, e_cb});
        chk("addr_c", {row_addr_c, col_addr_c}, {e_rc, e_cc});
        if (e_we) chk("data_c", data_in_c, e_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_c();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                mem_c[i][j] = '0;
                wr_flag[i][j] = 0;
            end
    endtask

    task automatic load_rand();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) mem_a[i][k] = $urandom;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) mem_b[k][j] = $urandom;
    endtask

    // Pulse start and wait for done; returns cycles counted from start
    task automatic run(output int cyc);
        cyc = -1;
        start = 1;
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (n == 1) start = 0;
            if (done) begin cyc = n; break; end
        end
        if (cyc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_all_c(input string name);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) chk(name, mem_c[i][j], ref_c(i, j));
    endtask

    int cyc, w0, nw;
    logic [RW-1:0] c_lit [M][N];

    initial begin
        c_lit = '{'{87,95,88,94}, '{95,87,94,88}, '{94,88,87,95}, '{88,94,95,87}};
        mem_a = '{'{4,3,2,5}, '{3,4,5,2}, '{5,2,4,3}, '{2,5,3,4}};
        mem_b = '{'{7,6,5,8}, '{6,7,8,5}, '{8,5,7,6}, '{5,8,6,7}};
        clear_c();

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {matrix_a_re, matrix_b_re, matrix_c_we}, 0);
        chk("rst_addr", {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}, 0);
        chk("rst_data", data_in_c, 0);
        tick(); tick();
        resetn = 1;
        tick();

        // Basic product with literal results
        w0 = wr_count;
        run(cyc);
        chk("basic_done_cycle", cyc, 145);
        tick();
        chk("basic_writes", wr_count - w0, 16);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) chk("basic_c", mem_c[i][j], c_lit[i][j]);

        // Handshake: start held through the run, then restart after done
        clear_c();
        w0 = wr_count;
        start = 1;
        cyc = -1;
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (done) begin cyc = n; break; end
        end
        chk("hs_done_cycle", cyc, 145);
        tick();
        tick();
        start = 0;
        chk("hs_busy_restart", busy, 1);
        cyc = -1;
        for (int n = 2; n <= 1000; n++) begin
            tick();
            if (done) begin cyc = n; break; end
        end
        chk("hs_done2_cycle", cyc, 145);
        tick();
        chk("hs_writes", wr_count - w0, 32);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) chk("hs_c", mem_c[i][j], c_lit[i][j]);

        // Abort in the third write
        clear_c();
        w0 = wr_count;
        nw = 0;
        start = 1;
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (n == 1) start = 0;
            if (matrix_c_we) nw++;
            if (nw == 3) break;
        end
        chk("abort_reached", nw, 3);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", busy, 0);
        for (int n = 0; n < 40; n++) begin
            if (done) chk("abort_no_done", done, 0);
            tick();
        end
        chk("abort_writes", wr_count - w0, 3);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                chk("abort_flag", wr_flag[i][j], (i == 0 && j < 3) ? 1 : 0);
        for (int j = 0; j < 3; j++) chk("abort_c", mem_c[0][j], c_lit[0][j]);

        // Start together with abort in IDLE: abort wins
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("abort_vs_start", busy, 0);
        tick();

        // Width edge: all ones
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) begin mem_a[i][k] = '1; mem_b[k][i] = '1; end
        clear_c();
        run(cyc);
        tick();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
`ifdef MAC_STOP_CTRL_SIGNED_EN
                chk("width_c", mem_c[i][j], 66'd4);
`else
                chk("width_c", mem_c[i][j], 66'h3_FFFF_FFF8_0000_0004);
`endif

        // Reset in the middle of a MAC, then a fresh run
        load_rand();
        clear_c();
        start = 1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) start = 0;
        end
        resetn = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_strobes", {matrix_a_re, matrix_b_re, matrix_c_we, done}, 0);
        chk("mid_rst_addr", {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}, 0);
        chk("mid_rst_data", data_in_c, 0);
        tick(); tick();
        resetn = 1;
        tick();
        load_rand();
        clear_c();
        run(cyc);
        tick();
        check_all_c("post_rst_c");

`ifdef MAC_STOP_CTRL_SIGNED_EN
        // Signed dot product
        mem_a[0] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd4};
        mem_b[0][0] = 32'd5; mem_b[1][0] = 32'hFFFF_FFFA;
        mem_b[2][0] = 32'd7; mem_b[3][0] = 32'd8;
        clear_c();
        run(cyc);
        tick();
        chk("signed_c00", mem_c[0][0], -66'sd6);
`endif

        // Random runs with random idle gaps
        for (int r = 0; r < 3; r++) begin
            load_rand();
            clear_c();
            for (int g = 0; g < int'($urandom_range(0, 5)); g++) tick();
            run(cyc);
            chk("rand_done_cycle", cyc, 145);
            tick();
            check_all_c("rand_c");
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_stop_ctrl.md
# mac_stop_ctrl

Sequencer for the `mac_stop_mem` matrix store. On a start pulse it computes C = A × B, with A of size M×K and B of size K×N. It reads A and B element by element through the memory read ports, multiply-accumulates each dot product, and writes each C element through the memory C write port. It sits between the host/test interface and `mac_stop_mem`, and owns the A/B read ports and the C write port while busy.

## Interface
Parameters:
- M, 4, rows of A and C
- K, 4, columns of A / rows of B (dot-product length)
- N, 4, columns of B and C
- DATA_WIDTH_INIT_MATRIX, 32, A/B element width
- DATA_WIDTH_RESULT_MATRIX, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K), C element / accumulator width

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a computation; sampled in IDLE only
- abort  in  1  synchronous stop request; honoured in any state other than IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when all M*N results are written
- row_addr_a  out  $clog2(M)  A row address (i)
- col_addr_a  out  $clog2(K)  A column address (k)
- row_addr_b  out  $clog2(K)  B row address (k)
- col_addr_b  out  $clog2(N)  B column address (j)
- matrix_a_re, matrix_b_re  out  1  read strobes
- data_out_a, data_out_b  in  DATA_WIDTH_INIT_MATRIX  memory read data, valid the cycle after the strobe
- row_addr_c  out  $clog2(M)  C row address
- col_addr_c  out  $clog2(N)  C column address
- matrix_c_we  out  1  C write strobe
- data_in_c  out  DATA_WIDTH_RESULT_MATRIX  C write data (the accumulator)

## Operation
- **States:** IDLE, FETCH, MAC, WRITE, DONE.
- **Counters:** i (0..M-1), j (0..N-1), k (0..K-1).
- **IDLE:**
  - On start=1 (and abort=0): clear i, j, k and acc, then go to FETCH.
  - Otherwise stay.
- **FETCH:**
  - Drive row_addr_a=i, col_addr_a=k, row_addr_b=k, col_addr_b=j.
  - Assert matrix_a_re=matrix_b_re=1.
  - Go to MAC.
- **MAC:**
  - Update acc <= acc + ext(data_out_a) * ext(data_out_b).
  - If k==K-1, go to WRITE; otherwise k++ and go to FETCH.
- **WRITE:**
  - Drive row_addr_c=i, col_addr_c=j, data_in_c=acc, matrix_c_we=1.
  - Then clear acc and set k=0.
  - If j<N-1: j++ and go to FETCH.
  - Else if i<M-1: j=0, i++ and go to FETCH.
  - Else go to DONE.
- **DONE:** done=1 for this cycle, then go to IDLE.
- **Elements written** in row-major order: (0,0), (0,1) … (M-1,N-1).
- **Arithmetic:**
  - Each product is 2*DATA_WIDTH_INIT_MATRIX bits, extended to DATA_WIDTH_RESULT_MATRIX.
  - acc cannot overflow for K terms; no saturation.
- **Strobes and addresses:**
  - Strobes are high only in the states listed above.
  - Address outputs hold their last driven value when their strobe is low.
- **start handling:** start is ignored while busy; it is not queued.
- **abort:** any non-IDLE state goes to IDLE on the next edge.
  - No further strobes are issued and done does not pulse.
  - C elements already written remain in memory.
  - If abort occurs in WRITE, that cycle's write still occurs (the strobe is already driven); it is the last write.
- **start with abort in IDLE:** abort wins; the block stays in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters and acc 0.
- **Mid-operation reset:** asserting resetn low mid-operation returns all outputs to 0 immediately (asynchronous).
- **Memory read latency:** exactly 1 cycle; the data is consumed in MAC.
- **Cycles per C element:** 2K+1.
- **Total latency:** done is high on cycle M*N*(2K+1)+1 after the edge that accepted start. For the defaults that is cycle 145.
- **busy:** rises on the edge after start is accepted; falls on the edge after the done cycle.
- **Back-to-back runs:** a new start is accepted in IDLE on the cycle after DONE.

## Configuration
- **MAC_STOP_CTRL_SIGNED_EN defined:**
  - data_out_a/b are treated as two's complement.
  - Products are signed, sign-extended into acc; data_in_c is a two's-complement result.
- **Undefined (default):**
  - Operands are unsigned, zero-extended.
  - All arithmetic is unsigned.

## Test plan
- **Basic product (default params, unsigned):**
  - Stimulus: memory behavioural model preloaded with A = {4,3,2,5; 3,4,5,2; 5,2,4,3; 2,5,3,4} and B = {7,6,5,8; 6,7,8,5; 8,5,7,6; 5,8,6,7}; pulse start.
  - Required response: C = {87,95,88,94; 95,87,94,88; 94,88,87,95; 88,94,95,87}, written row-major; done on cycle 145; exactly 16 matrix_c_we pulses.
- **Handshake:**
  - Stimulus: start held high through the whole run, then a second start in the cycle after done.
  - Required response: the second run completes with identical results; the held start during busy causes no restart.
- **Abort:**
  - Stimulus: abort asserted in the 3rd WRITE.
  - Required response: exactly 3 writes, for (0,0), (0,1) and (0,2); busy low next cycle; no done pulse.
- **Reset:**
  - Stimulus: resetn low mid-MAC, then released.
  - Required response: outputs 0 asynchronously; a fresh start produces correct C from scratch, with acc cleared.
- **Width edge:**
  - Stimulus: all A and B elements = 0xFFFFFFFF, unsigned.
  - Required response: every C element = 4*(2^32-1)^2, no wrap.
- **Signed build (MAC_STOP_CTRL_SIGNED_EN):**
  - Stimulus: A row 0 = {-1,2,-3,4}; B column 0 = {5,-6,7,8}.
  - Required response: C[0][0] = -5-12-21+32 = -6.
